// File: rtl/instruction_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package instruction_fetch_queue_pkg;

  localparam int INST_BYTES = 4;

  // All-zero bubble word; decode treats it as a no-op, so an idle head reads as 0.
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Synchronous circular FIFO with push, pop, flush and occupancy count.
// Used both for prefetched instructions and for in-order request address tags.
module fetch_queue_fifo
  import instruction_fetch_queue_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;

  // Wraps explicitly so DEPTH need not be a power of two (tag queue uses MAX_OUT).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset && !flush) assert (!(push && !do_pop && count == CNT_W'(DEPTH)));
  end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Prefetching fetch stage: issues in-order memory requests, queues responses for decode.
// Optional IFQ_TRACE_EN adds a simulation-only cycle counter and pop/redirect trace.
module instruction_fetch_queue
  import instruction_fetch_queue_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter int                MAX_OUT  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_W-1:0]      mem_req_addr,
  input  logic                   mem_resp_valid,
  input  logic [INST_W-1:0]      mem_resp_inst,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      out_pc,
  output logic [INST_W-1:0]      out_inst,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OUT_W = $clog2(MAX_OUT) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  typedef logic [ADDR_W-1:0] tag_t;

  logic [ADDR_W-1:0] pc;
  logic [OUT_W-1:0]  outstanding;
  logic [OUT_W-1:0]  outstanding_nxt;
  logic [OUT_W-1:0]  drop;
  logic [31:0]       reserved;
  logic              req_fire;
  logic              resp_keep;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              tag_empty;
  tag_t              tag_head;
  entry_t            push_entry;
  entry_t            head_entry;

  // Reserved space counts requests in flight that will still land in the FIFO.
  assign reserved        = 32'(fifo_count) + 32'(outstanding) - 32'(drop);
  assign mem_req_valid   = reset && (outstanding < OUT_W'(MAX_OUT)) && (reserved < 32'(DEPTH));
  assign mem_req_addr    = pc;
  assign req_fire        = mem_req_valid && mem_req_ready;
  assign outstanding_nxt = outstanding + OUT_W'(req_fire) - OUT_W'(mem_resp_valid);
  assign resp_keep       = mem_resp_valid && (drop == '0) && !redirect_valid;
  assign fifo_pop        = out_valid && out_ready;

  assign push_entry.pc   = tag_head;
  assign push_entry.inst = mem_resp_inst;

  assign out_valid = !fifo_empty;
  assign out_pc    = fifo_empty ? '0 : head_entry.pc;
  assign out_inst  = fifo_empty ? INST_W'(NOP_INST) : head_entry.inst;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc   <= RESET_PC;
      drop <= '0;
    end else if (redirect_valid) begin
      pc   <= redirect_pc;
      drop <= outstanding_nxt;
    end else begin
      if (req_fire) pc <= pc + ADDR_W'(INST_BYTES);
      if (mem_resp_valid && drop != '0) drop <= drop - 1'b1;
    end
  end

  // Tag queue occupancy is the outstanding-request count; it survives redirects
  // so that late responses still pop their own tag.
  fetch_queue_fifo #(
    .DEPTH   (MAX_OUT),
    .entry_t (tag_t)
  ) u_tag_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (pc),
    .pop       (mem_resp_valid),
    .head      (tag_head),
    .empty     (tag_empty),
    .count     (outstanding)
  );

  fetch_queue_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_inst_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (resp_keep),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head_entry),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      assert (fifo_count <= CNT_W'(DEPTH));
      assert (outstanding <= OUT_W'(MAX_OUT));
      assert (!(mem_resp_valid && tag_empty));
    end
  end

`ifdef IFQ_TRACE_EN
  longint unsigned trace_cycle;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) trace_cycle <= 0;
    else        trace_cycle <= trace_cycle + 1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      if (fifo_pop)       $display("IFQ(%0d): @%h: %h", trace_cycle, out_pc, out_inst);
      if (redirect_valid) $display("IFQ REDIRECT -> %h, dropped %0d", redirect_pc, outstanding_nxt);
    end
  end
`else
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue with an in-order variable-latency memory model.
module tb_instruction_fetch_queue;

  localparam int ADDR_W  = 32;
  localparam int INST_W  = 32;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;

  logic              clock = 1'b0;
  logic              rst_n = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_resp_valid = 1'b0;
  logic [INST_W-1:0] mem_resp_inst = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] out_pc;
  logic [INST_W-1:0] out_inst;
  logic [$clog2(DEPTH):0] fifo_count;

  int          total = 0;
  int          bad   = 0;
  int          lat   = 1;
  int          cyc   = 0;
  int          found;
  logic [31:0] exp_pc = '0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend[$];

  instruction_fetch_queue #(
    .ADDR_W   (ADDR_W),
    .INST_W   (INST_W),
    .DEPTH    (DEPTH),
    .MAX_OUT  (MAX_OUT),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clock          (clock),
    .reset          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_inst  (mem_resp_inst),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .fifo_count     (fifo_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // In-order memory: a request accepted at edge c is answered in the cycle sampled at edge c+lat.
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      mem_resp_valid <= 1'b0;
      mem_resp_inst  <= '0;
    end else begin
      cyc = cyc + 1;
      if (mem_resp_valid && pend.size() > 0) void'(pend.pop_front());
      if (mem_req_valid && mem_req_ready) pend.push_back('{mem_req_addr, cyc + lat});
      if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
        mem_resp_valid <= 1'b1;
        mem_resp_inst  <= inst_of(pend[0].addr);
      end else begin
        mem_resp_valid <= 1'b0;
        mem_resp_inst  <= '0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Checks any pop at the falling edge, then advances to just after the next rising edge.
  task automatic tick();
    logic        rd;
    logic [31:0] rpc;
    @(negedge clock);
    if (out_valid && out_ready) begin
      chk("pop_pc", out_pc, exp_pc);
      chk("pop_inst", out_inst, inst_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    rd  = redirect_valid;
    rpc = redirect_pc;
    @(posedge clock);
    #1;
    if (rd) exp_pc = rpc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #2;
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    @(posedge clock);
    @(posedge clock);
    #1;
    lat = 1; mem_req_ready = 1'b1; out_ready = 1'b1; exp_pc = 32'h0;
    rst_n = 1'b1;
    #1;
    chk("t1_req_valid", 32'(mem_req_valid), 32'd1);
    chk("t1_req_addr0", mem_req_addr, 32'h0);

    // 1: streaming at one instruction per cycle
    tick();
    chk("t1_req_addr1", mem_req_addr, 32'h4);
    chk("t1_no_out_yet", 32'(out_valid), 32'd0);
    tick();
    chk("t1_first_valid", 32'(out_valid), 32'd1);
    chk("t1_first_pc", out_pc, 32'h0);
    chk("t1_first_count", 32'(fifo_count), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t1_steady_count", 32'(fifo_count), 32'd1);
      chk("t1_steady_valid", 32'(out_valid), 32'd1);
    end

    // 2: decode stall fills the FIFO, issue stops on reserved space
    out_ready = 1'b0;
    tick();
    chk("t2_count2", 32'(fifo_count), 32'd2);
    tick();
    chk("t2_count3", 32'(fifo_count), 32'd3);
    chk("t2_req_stop", 32'(mem_req_valid), 32'd0);
    repeat (8) tick();
    chk("t2_count_full", 32'(fifo_count), 32'd4);
    chk("t2_req_still_stop", 32'(mem_req_valid), 32'd0);
    chk("t2_head_held", out_pc, exp_pc);
    out_ready = 1'b1;
    repeat (12) tick();

    // 4: redirect coinciding with a response and a request accept
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("t4_flush_valid", 32'(out_valid), 32'd0);
    chk("t4_flush_count", 32'(fifo_count), 32'd0);
    chk("t4_req_valid", 32'(mem_req_valid), 32'd1);
    chk("t4_req_addr", mem_req_addr, 32'h100);
    tick();
    chk("t4_dropped", 32'(out_valid), 32'd0);
    tick();
    chk("t4_first_valid", 32'(out_valid), 32'd1);
    chk("t4_first_pc", out_pc, 32'h100);
    repeat (4) tick();

    // 6: PC wraps past the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("t6_req_valid", 32'(mem_req_valid), 32'd1);
    chk("t6_req_top", mem_req_addr, 32'hFFFF_FFFC);
    tick();
    chk("t6_req_wrap", mem_req_addr, 32'h0);
    repeat (5) tick();

    // 5: asynchronous reset with three entries queued
    out_ready = 1'b0;
    tick();
    tick();
    chk("t5_count3", 32'(fifo_count), 32'd3);
    chk("t5_req_stop", 32'(mem_req_valid), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 32'(out_valid), 32'd0);
    chk("t5_async_count", 32'(fifo_count), 32'd0);
    chk("t5_async_req", 32'(mem_req_valid), 32'd0);
    chk("t5_async_out_pc", out_pc, 32'h0);
    @(posedge clock);
    @(posedge clock);
    #1;
    lat = 3; out_ready = 1'b1; exp_pc = 32'h0;
    rst_n = 1'b1;
    #1;
    chk("t5_req_valid", 32'(mem_req_valid), 32'd1);
    chk("t5_req_reset_pc", mem_req_addr, 32'h0);

    // 3: three-cycle memory, redirect with two requests outstanding
    tick();
    chk("t3_req_addr1", mem_req_addr, 32'h4);
    tick();
    chk("t3_max_out", 32'(mem_req_valid), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("t3_redir_valid", 32'(out_valid), 32'd0);
    chk("t3_redir_req", 32'(mem_req_valid), 32'd0);
    tick();
    chk("t3_resume_req", 32'(mem_req_valid), 32'd1);
    chk("t3_resume_addr", mem_req_addr, 32'h100);
    chk("t3_drop0", 32'(out_valid), 32'd0);
    tick();
    chk("t3_drop1", 32'(out_valid), 32'd0);
    chk("t3_next_addr", mem_req_addr, 32'h104);
    found = 0;
    for (int i = 0; i < 12 && found == 0; i++) begin
      tick();
      if (out_valid) found = 1;
    end
    chk("t3_wait_valid", 32'(found), 32'd1);
    chk("t3_first_pc", out_pc, 32'h100);
    chk("t3_first_inst", out_inst, inst_of(32'h100));
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_queue.md
Name: instruction_fetch_queue

Overview:
Parametrised successor to the single-register fetch stage. It decouples PC generation from decode using a prefetch FIFO and a valid/ready request/response interface to a variable-latency, in-order instruction memory. It supports several outstanding requests, redirect (jump/branch) with discard of in-flight responses, and decode back-pressure. It sits between the instruction memory port and the IF/ID boundary; decode consumes entries through a valid/ready handshake.

Parameters:
ADDR_W, 32, PC and memory address width (bits)
INST_W, 32, instruction word width
DEPTH, 4, prefetch FIFO entries (power of two, >=2)
MAX_OUT, 2, max outstanding memory requests (1..DEPTH)
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-low reset
redirect_valid  in  1  jump/branch taken this cycle
redirect_pc  in  ADDR_W  new fetch target
mem_req_valid  out  1  fetch request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  fetch address
mem_resp_valid  in  1  response valid (in order, one per accepted request; no back-pressure)
mem_resp_inst  in  INST_W  returned instruction
out_valid  out  1  FIFO head valid to decode
out_ready  in  1  decode accepts head (low = stall)
out_pc  out  ADDR_W  PC of head entry
out_inst  out  INST_W  instruction of head entry
fifo_count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_PC; FIFO empty; outstanding=0; drop=0; mem_req_valid=0; out_valid=0; out_pc=0; out_inst=0; fifo_count=0. Reset mid-operation abandons all in-flight requests; memory is reset on the same signal.
- Issue: mem_req_valid = reset deasserted && outstanding<MAX_OUT && (fifo_count+outstanding-drop)<DEPTH. Space is reserved, so a response never finds the FIFO full. mem_req_addr=pc.
- Accept (req_valid&&req_ready): outstanding+1; pc<=pc+4 (mod 2^ADDR_W; wrap silent).
- Response: outstanding-1. If drop>0, drop-1 and the data is discarded. Otherwise push {pc_of_request, inst}; pc_of_request comes from an internal MAX_OUT-deep in-order address tag queue.
- Pop: out_valid&&out_ready removes the head. Push and pop in the same cycle keep the count unchanged. A response arriving while the FIFO is empty appears on out_* the following cycle (1-cycle registered latency).
- Redirect (priority over everything): pc<=redirect_pc; FIFO flushed (out_valid=0 next cycle); drop<=outstanding after this cycle's accept/response updates. A request accepted in the redirect cycle counts toward drop. A response in the redirect cycle is discarded. Issue resumes the next cycle from redirect_pc, without waiting for drop to reach 0.
- Back-to-back redirects: each one recomputes drop from the current outstanding count. Drop never exceeds outstanding.
- No FSM beyond counters. The invariants fifo_count<=DEPTH and outstanding<=MAX_OUT are checked with immediate assertions.

Optional Feature:
IFQ_TRACE_EN: when defined, a simulation-only cycle counter plus one $display per pop ("IFQ(cycle): @pc: inst") and one per redirect ("IFQ REDIRECT -> pc, dropped n"). When undefined, no trace logic or counter is compiled; ports and function are identical.

Decomposition:
- Shared package: fetch_entry_t {pc, inst} struct, INST_BYTES=4 constant, NOP encoding used for the out_inst reset value.
- One sub-module, fetch_queue_fifo: a synchronous DEPTH-entry FIFO of fetch_entry_t with push, pop, flush and count. It is reused for the address tag queue with DEPTH=MAX_OUT.

Test Plan:
1. Reset release, mem_req_ready=1, 1-cycle memory latency, out_ready=1 -> requests 0x0,0x4,0x8,…; pops with out_pc 0x0,0x4,… in order; steady state 1 instruction/cycle.
2. out_ready=0 for 10 cycles with DEPTH=4 -> fifo_count saturates at 4; mem_req_valid drops once fifo_count+outstanding=4; no entry lost or duplicated after out_ready=1.
3. 3-cycle memory latency, MAX_OUT=2, redirect to 0x100 while 2 requests are outstanding -> both responses discarded; next pop has out_pc=0x100.
4. Redirect in the same cycle as a response and a request accept -> response discarded; accepted request dropped; no FIFO entry before a PC of 0x100.
5. Assert reset low mid-stream with FIFO at 3 entries -> out_valid=0 and fifo_count=0 immediately (asynchronous); first request after release has address RESET_PC.
6. pc=32'hFFFF_FFFC with a request accepted -> next address is 0x0000_0000 (wrap).
